mem_port_arbiter: RTL and testbench

- Shares one single-port backing memory between the instruction-fetch requester (IM) and the data requester (DM) of the 5-stage RV32 core.
- Sits between the pipeline controller's IM_Mem_R/IM_Mem_W/DM_Mem_R/DM_Mem_W/IM_Valid/DM_Valid handshake and the memory.
- Serialises accesses, holds each request stable until the memory acknowledges, then returns data with a one-cycle Valid pulse.
- A watchdog aborts hung accesses.

---
 rtl/mem_port_arbiter_pkg.sv | 27 ++
 rtl/mem_port_arbiter_rr_arbiter2.sv | 54 +++++
 rtl/mem_port_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 479 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared types for the IM/DM memory port arbiter: FSM state and access-owner
// encodings, the wait-counter width, and the "is this requester pending" rule.
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IM = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Width of the ACCESS wait counter; bounds TIMEOUT_CYC to 1..255.
  localparam int WAIT_CNT_W = 8;

  // A requester wants the memory when it reads or writes any byte.
  function automatic logic is_pending(input logic rd, input logic [3:0] wr_mask);
    return rd | (|wr_mask);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter between IM and DM. The grant is combinational
// from the requests and the last_grant register; last_grant only moves when the
// caller strobes grant_stb, i.e. when the grant is actually taken.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset (last_grant -> OWN_IM)
//   req_im     IM pending
//   req_dm     DM pending
//   grant_stb  grant is consumed this cycle; record gnt_owner as last_grant
//   gnt_valid  at least one requester is pending
//   gnt_owner  requester that wins this cycle
// -----------------------------------------------------------------------------
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   req_im,
  input  logic   req_dm,
  input  logic   grant_stb,
  output logic   gnt_valid,
  output owner_t gnt_owner
);

  owner_t last_grant;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt_valid = req_im | req_dm;
    gnt_owner = OWN_IM;
    if (req_im && req_dm) begin
      // Tie: the side that did not win last time goes first.
      if (last_grant == OWN_IM) gnt_owner = OWN_DM;
      else                      gnt_owner = OWN_IM;
    end else if (req_dm) begin
      gnt_owner = OWN_DM;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= OWN_IM;
    end else if (grant_stb) begin
      last_grant <= gnt_owner;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch (IM) and data
// (DM) requesters. One access at a time: IDLE grants and latches the request,
// ACCESS holds mem_req with stable address/data until mem_ack or a timeout,
// RESP pulses the owner's Valid for one cycle with the returned data.
//
// Ports:
//   clk, rst                       clock, asynchronous active-low reset
//   IM_Mem_R/IM_Mem_W/IM_addr      IM request (read level, byte write mask)
//   IM_rdata/IM_Valid              IM response, Valid is a one-cycle pulse
//   DM_Mem_R/DM_Mem_W/DM_addr/
//   DM_wdata                       DM request
//   DM_rdata/DM_Valid              DM response, Valid is a one-cycle pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                      memory request, held until mem_ack
//   mem_ack/mem_rdata              memory completion and read data
//   bus_err                        sticky: some access timed out
// -----------------------------------------------------------------------------
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int memAddrWidth = 15,
  parameter int DATA_W       = 32,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    IM_Mem_R,
  input  logic [3:0]              IM_Mem_W,
  input  logic [memAddrWidth-1:0] IM_addr,
  output logic [DATA_W-1:0]       IM_rdata,
  output logic                    IM_Valid,
  input  logic                    DM_Mem_R,
  input  logic [3:0]              DM_Mem_W,
  input  logic [memAddrWidth-1:0] DM_addr,
  input  logic [DATA_W-1:0]       DM_wdata,
  output logic [DATA_W-1:0]       DM_rdata,
  output logic                    DM_Valid,
  output logic                    mem_req,
  output logic [3:0]              mem_we,
  output logic [memAddrWidth-1:0] mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_W-1:0]       mem_rdata,
  output logic                    bus_err
);

  // Last ACCESS cycle index before the watchdog fires.
  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT_CYC - 1);

  state_t                  state, next_state;
  owner_t                  owner, gnt_owner;
  logic                    gnt_valid;
  logic                    grant_stb, ack_done, time_out;
  logic [memAddrWidth-1:0] lat_addr;
  logic [DATA_W-1:0]       lat_wdata;
  logic [3:0]              lat_mask;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic [DATA_W-1:0]       im_rdata_q, dm_rdata_q, rd_val;
  logic                    bus_err_q;

  rr_arbiter2 u_rr (
    .clk       (clk),
    .rst       (rst),
    .req_im    (is_pending(IM_Mem_R, IM_Mem_W)),
    .req_dm    (is_pending(DM_Mem_R, DM_Mem_W)),
    .grant_stb (grant_stb),
    .gnt_valid (gnt_valid),
    .gnt_owner (gnt_owner)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    grant_stb  = 1'b0;
    ack_done   = 1'b0;
    time_out   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_valid) begin
          grant_stb  = 1'b1;
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        // An ack in the final allowed cycle still counts as a completion.
        if (mem_ack) begin
          ack_done   = 1'b1;
          next_state = RESP;
        end else if (wait_cnt == WAIT_LAST) begin
          time_out   = 1'b1;
          next_state = RESP;
        end
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Writes and aborted accesses return zero data.
  always_comb begin
    rd_val = '0;
    if (ack_done && lat_mask == 4'b0000) rd_val = mem_rdata;
  end

  // ---------------------------------------------------------------------------
  // Request latches, wait counter, response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_IM;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_mask   <= '0;
      wait_cnt   <= '0;
      im_rdata_q <= '0;
      dm_rdata_q <= '0;
      bus_err_q  <= 1'b0;
    end else begin
      if (grant_stb) begin
        owner    <= gnt_owner;
        wait_cnt <= '0;
        if (gnt_owner == OWN_DM) begin
          lat_addr  <= DM_addr;
          lat_wdata <= DM_wdata;
          lat_mask  <= DM_Mem_W;
        end else begin
          // IM has no write-data port; an IM write stores zeros under its mask.
          lat_addr  <= IM_addr;
          lat_wdata <= '0;
          lat_mask  <= IM_Mem_W;
        end
      end

      if (state == ACCESS && !ack_done && !time_out) begin
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end

      if (ack_done || time_out) begin
        if (owner == OWN_DM) dm_rdata_q <= rd_val;
        else                 im_rdata_q <= rd_val;
      end

      if (time_out) bus_err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven from registers, no combinational path from requesters.
  // ---------------------------------------------------------------------------
  assign mem_req   = (state == ACCESS);
  assign mem_we    = mem_req ? lat_mask : 4'b0000;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;

  assign IM_Valid  = (state == RESP) && (owner == OWN_IM);
  assign DM_Valid  = (state == RESP) && (owner == OWN_DM);
  assign IM_rdata  = im_rdata_q;
  assign DM_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
// Drives IM/DM requests against a behavioural memory responder. Expected grant
// order, response cycles and data come from a transaction-level model: each
// access takes one grant cycle, N memory cycles and one response cycle, and
// accesses run one after another.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 15;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    logic [AW-1:0] addr;
    logic [3:0]    we;
    logic [DW-1:0] wdata;
    int            len;
  } bus_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          IM_Mem_R = 1'b0;
  logic [3:0]    IM_Mem_W = 4'h0;
  logic [AW-1:0] IM_addr = '0;
  logic [DW-1:0] IM_rdata;
  logic          IM_Valid;
  logic          DM_Mem_R = 1'b0;
  logic [3:0]    DM_Mem_W = 4'h0;
  logic [AW-1:0] DM_addr = '0;
  logic [DW-1:0] DM_wdata = '0;
  logic [DW-1:0] DM_rdata;
  logic          DM_Valid;
  logic          mem_req;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          bus_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .memAddrWidth (AW),
    .DATA_W       (DW),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .IM_Mem_R  (IM_Mem_R),
    .IM_Mem_W  (IM_Mem_W),
    .IM_addr   (IM_addr),
    .IM_rdata  (IM_rdata),
    .IM_Valid  (IM_Valid),
    .DM_Mem_R  (DM_Mem_R),
    .DM_Mem_W  (DM_Mem_W),
    .DM_addr   (DM_addr),
    .DM_wdata  (DM_wdata),
    .DM_rdata  (DM_rdata),
    .DM_Valid  (DM_Valid),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .bus_err   (bus_err)
  );

  // ---------------------------------------------------------------------------
  // Memory contents: phys_mem is what the responder holds, ref_mem is the
  // model's prediction. Unwritten words read as a fixed hash of the address.
  // ---------------------------------------------------------------------------
  logic [DW-1:0] phys_mem [logic [AW-1:0]];
  logic [DW-1:0] ref_mem  [logic [AW-1:0]];

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return ({17'd0, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old,
                                          input logic [DW-1:0] data,
                                          input logic [3:0] mask);
    logic [DW-1:0] r = old;
    for (int i = 0; i < 4; i++) if (mask[i]) r[8*i +: 8] = data[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  function automatic logic [DW-1:0] phys_read(input logic [AW-1:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
  endfunction

  // ---------------------------------------------------------------------------
  // Memory responder: acks in the ack_lat-th cycle of mem_req (0 = never),
  // checks the request stays stable, and logs every access when mem_req falls.
  // ---------------------------------------------------------------------------
  int            ack_lat  = 1;
  bit            spurious = 1'b0;
  int            acc_cnt  = 0;
  logic [AW-1:0] cap_addr;
  logic [3:0]    cap_we;
  logic [DW-1:0] cap_wdata;
  bus_t          bus_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      acc_cnt = 0;
      mem_ack = 1'b0;
    end else if (mem_req) begin
      acc_cnt++;
      if (acc_cnt == 1) begin
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
      end else begin
        checks++;
        if ({mem_addr, mem_we, mem_wdata} !== {cap_addr, cap_we, cap_wdata}) begin
          errors++;
          $display("FAIL bus_stable: got addr=%h we=%b wdata=%h want addr=%h we=%b wdata=%h",
                   mem_addr, mem_we, mem_wdata, cap_addr, cap_we, cap_wdata);
        end
      end
      if (ack_lat != 0 && acc_cnt == ack_lat) begin
        mem_ack = 1'b1;
        if (mem_we == 4'h0) begin
          mem_rdata = phys_read(mem_addr);
        end else begin
          mem_rdata = $urandom;
          phys_mem[mem_addr] = merge(phys_read(mem_addr), mem_wdata, mem_we);
        end
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
      end
    end else begin
      if (acc_cnt != 0) bus_q.push_back('{cap_addr, cap_we, cap_wdata, acc_cnt});
      acc_cnt   = 0;
      mem_ack   = spurious;
      mem_rdata = $urandom;
    end
  end

  // Model state: side that won the last grant (0 = IM, 1 = DM) and bus_err.
  bit model_last = 1'b0;
  bit model_err  = 1'b0;

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    IM_Mem_R = 1'b0; IM_Mem_W = 4'h0; DM_Mem_R = 1'b0; DM_Mem_W = 4'h0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_last = 1'b0;
    model_err  = 1'b0;
    bus_q.delete();
  endtask

  // ---------------------------------------------------------------------------
  // One scenario: IM read and/or DM access issued together from idle.
  // lat = memory cycles per access (0 = never ack); im_drop = cycle at which
  // IM withdraws its request early (0 = hold until Valid).
  // ---------------------------------------------------------------------------
  task automatic run_case(input string name,
                          input bit im_en, input logic [AW-1:0] im_a,
                          input bit dm_en, input logic [AW-1:0] dm_a,
                          input logic [3:0] dm_m, input logic [DW-1:0] dm_d,
                          input int lat, input int im_drop);
    bit            order[$];
    int            exp_vc[2];
    logic [DW-1:0] exp_data[2];
    int            s, acc, last_vc;
    int            n_im, n_dm, vc_im, vc_dm;
    logic [DW-1:0] d_im, d_dm;
    logic [3:0]    exp_we;
    bus_t          b;

    if (im_en && dm_en) begin
      order.push_back(!model_last);
      order.push_back(model_last);
    end else if (im_en) begin
      order.push_back(1'b0);
    end else if (dm_en) begin
      order.push_back(1'b1);
    end
    acc = (lat == 0) ? TO : lat;
    s   = 1;
    foreach (order[k]) begin
      int o;
      o = int'(order[k]);
      exp_vc[o] = s + acc + 1;
      if (lat == 0) begin
        exp_data[o] = '0;
      end else if (o == 1 && dm_m != 4'h0) begin
        exp_data[o] = '0;
        ref_mem[dm_a] = merge(ref_read(dm_a), dm_d, dm_m);
      end else begin
        exp_data[o] = ref_read(o == 1 ? dm_a : im_a);
      end
      s = exp_vc[o] + 1;
      model_last = order[k];
    end
    if (lat == 0) model_err = 1'b1;
    last_vc = s - 1;

    @(negedge clk);
    ack_lat  = lat;
    IM_Mem_R = im_en;
    IM_Mem_W = 4'h0;
    IM_addr  = im_a;
    DM_Mem_R = dm_en && (dm_m == 4'h0 || $urandom_range(0, 1) == 1);
    DM_Mem_W = dm_en ? dm_m : 4'h0;
    DM_addr  = dm_a;
    DM_wdata = dm_d;
    n_im = 0; n_dm = 0; vc_im = 0; vc_dm = 0; d_im = '0; d_dm = '0;
    for (int c = 1; c <= last_vc + 4; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (IM_Valid) begin
        n_im++; vc_im = c + 1; d_im = IM_rdata; IM_Mem_R = 1'b0;
      end
      if (DM_Valid) begin
        n_dm++; vc_dm = c + 1; d_dm = DM_rdata; DM_Mem_R = 1'b0; DM_Mem_W = 4'h0;
      end
      if (im_drop > 0 && c == im_drop) IM_Mem_R = 1'b0;
    end

    checks++;
    if (n_im != (im_en ? 1 : 0)) begin
      errors++;
      $display("FAIL %s im_valid_count: got %0d want %0d", name, n_im, im_en ? 1 : 0);
    end
    checks++;
    if (n_dm != (dm_en ? 1 : 0)) begin
      errors++;
      $display("FAIL %s dm_valid_count: got %0d want %0d", name, n_dm, dm_en ? 1 : 0);
    end
    if (im_en) begin
      checks++;
      if (vc_im != exp_vc[0]) begin
        errors++;
        $display("FAIL %s im_valid_cycle: got %0d want %0d", name, vc_im, exp_vc[0]);
      end
      checks++;
      if (d_im !== exp_data[0]) begin
        errors++;
        $display("FAIL %s im_rdata: got %h want %h", name, d_im, exp_data[0]);
      end
    end
    if (dm_en) begin
      checks++;
      if (vc_dm != exp_vc[1]) begin
        errors++;
        $display("FAIL %s dm_valid_cycle: got %0d want %0d", name, vc_dm, exp_vc[1]);
      end
      checks++;
      if (d_dm !== exp_data[1]) begin
        errors++;
        $display("FAIL %s dm_rdata: got %h want %h", name, d_dm, exp_data[1]);
      end
    end

    checks++;
    if (bus_q.size() != order.size()) begin
      errors++;
      $display("FAIL %s bus_access_count: got %0d want %0d", name, bus_q.size(), order.size());
    end else begin
      foreach (order[k]) begin
        b = bus_q[k];
        exp_we = order[k] ? dm_m : 4'h0;
        checks++;
        if (b.addr !== (order[k] ? dm_a : im_a) || b.we !== exp_we || b.len != acc ||
            (exp_we != 4'h0 && b.wdata !== dm_d)) begin
          errors++;
          $display("FAIL %s bus_access%0d: got addr=%h we=%b wdata=%h len=%0d want addr=%h we=%b wdata=%h len=%0d",
                   name, k, b.addr, b.we, b.wdata, b.len,
                   order[k] ? dm_a : im_a, exp_we, dm_d, acc);
        end
      end
    end
    bus_q.delete();

    checks++;
    if (bus_err !== model_err) begin
      errors++;
      $display("FAIL %s bus_err: got %b want %b", name, bus_err, model_err);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, IM_Valid, DM_Valid, IM_rdata, DM_rdata, bus_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h iv=%b dv=%b ird=%h drd=%h err=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, IM_Valid, DM_Valid, IM_rdata, DM_rdata, bus_err);
    end
    rst = 1'b1;
    // mem_ack with no request outstanding must do nothing.
    spurious = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || IM_Valid !== 1'b0 || DM_Valid !== 1'b0) begin
        errors++;
        $display("FAIL spurious_ack: got req=%b iv=%b dv=%b want 0 0 0", mem_req, IM_Valid, DM_Valid);
      end
    end
    spurious = 1'b0;
  endtask

  task automatic test_im_read();
    phys_mem[15'h0040] = 32'h0000_0013;
    ref_mem[15'h0040]  = 32'h0000_0013;
    run_case("im_read", 1'b1, 15'h0040, 1'b0, '0, 4'h0, '0, 1, 0);
  endtask

  task automatic test_dm_write();
    run_case("dm_write", 1'b0, '0, 1'b1, 15'h1000, 4'b0011, 32'hDEAD_BEEF, 4, 0);
    run_case("dm_readback", 1'b0, '0, 1'b1, 15'h1000, 4'h0, '0, 2, 0);
  endtask

  task automatic test_tie_from_reset();
    apply_reset();
    run_case("tie_a", 1'b1, 15'h0010, 1'b1, 15'h4010, 4'h0, '0, 1, 0);
    run_case("tie_b", 1'b1, 15'h0014, 1'b1, 15'h4014, 4'h0, '0, 1, 0);
  endtask

  // Both requesters hold their request continuously, moving to a new address
  // after each Valid: grants alternate and each access takes 3 cycles.
  task automatic test_back_to_back();
    logic [AW-1:0] ia[2];
    logic [AW-1:0] da[2];
    bit            exp_o[4];
    logic [AW-1:0] exp_a[4];
    bit            obs_o[$];
    int            obs_vc[$];
    logic [DW-1:0] obs_d[$];
    int            ii, di;
    ia[0] = 15'h0100; ia[1] = 15'h0104;
    da[0] = 15'h4100; da[1] = 15'h4104;
    for (int k = 0; k < 4; k++) begin
      exp_o[k] = (k % 2 == 0) ? !model_last : model_last;
      exp_a[k] = exp_o[k] ? da[k / 2] : ia[k / 2];
    end
    model_last = exp_o[3];

    @(negedge clk);
    ack_lat = 1;
    ii = 0; di = 0;
    IM_Mem_R = 1'b1; IM_Mem_W = 4'h0; IM_addr = ia[0];
    DM_Mem_R = 1'b1; DM_Mem_W = 4'h0; DM_addr = da[0];
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (IM_Valid) begin
        obs_o.push_back(1'b0); obs_vc.push_back(c + 1); obs_d.push_back(IM_rdata);
        ii++;
        if (ii < 2) IM_addr = ia[ii]; else IM_Mem_R = 1'b0;
      end
      if (DM_Valid) begin
        obs_o.push_back(1'b1); obs_vc.push_back(c + 1); obs_d.push_back(DM_rdata);
        di++;
        if (di < 2) DM_addr = da[di]; else DM_Mem_R = 1'b0;
      end
    end

    checks++;
    if (obs_o.size() != 4 || bus_q.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got valids=%0d accesses=%0d want 4 4", obs_o.size(), bus_q.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (obs_o[k] !== exp_o[k] || obs_vc[k] != 3 * (k + 1) ||
            obs_d[k] !== ref_read(exp_a[k]) || bus_q[k].addr !== exp_a[k]) begin
          errors++;
          $display("FAIL b2b_access%0d: got owner=%0d cycle=%0d data=%h addr=%h want owner=%0d cycle=%0d data=%h addr=%h",
                   k, obs_o[k], obs_vc[k], obs_d[k], bus_q[k].addr,
                   exp_o[k], 3 * (k + 1), ref_read(exp_a[k]), exp_a[k]);
        end
      end
    end
    bus_q.delete();
  endtask

  task automatic test_timeout();
    run_case("dm_timeout", 1'b0, '0, 1'b1, 15'h4040, 4'h0, '0, 0, 0);
    run_case("after_timeout", 1'b1, 15'h0044, 1'b0, '0, 4'h0, '0, 2, 0);
  endtask

  task automatic test_withdraw();
    run_case("im_withdraw", 1'b1, 15'h0080, 1'b0, '0, 4'h0, '0, 4, 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int         mode;
      bit         wr;
      logic [3:0] m;
      mode = $urandom_range(0, 2);
      wr   = ($urandom_range(0, 1) == 1);
      m    = wr ? 4'($urandom_range(1, 15)) : 4'h0;
      run_case($sformatf("rand%0d", i),
               mode != 1, AW'($urandom_range(0, 63) << 2),
               mode != 0, 15'h4000 | AW'($urandom_range(0, 7) << 2),
               m, $urandom, $urandom_range(1, 4), 0);
    end
  endtask

  // Reset during a write that is never acked: outputs clear immediately,
  // and nothing completes afterwards.
  task automatic test_reset_mid_access();
    int n_valid, n_req;
    @(negedge clk);
    ack_lat  = 0;
    DM_Mem_R = 1'b0; DM_Mem_W = 4'hF; DM_addr = 15'h4200; DM_wdata = 32'hCAFE_F00D;
    repeat (3) @(negedge clk);
    checks++;
    if (mem_req !== 1'b1 || bus_err !== 1'b1) begin
      errors++;
      $display("FAIL mid_access_precondition: got req=%b err=%b want 1 1", mem_req, bus_err);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, IM_Valid, DM_Valid, IM_rdata, DM_rdata, bus_err} !== '0) begin
      errors++;
      $display("FAIL async_reset_outputs: got req=%b we=%b addr=%h wdata=%h iv=%b dv=%b ird=%h drd=%h err=%b want all 0",
               mem_req, mem_we, mem_addr, mem_wdata, IM_Valid, DM_Valid, IM_rdata, DM_rdata, bus_err);
    end
    DM_Mem_W = 4'h0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_last = 1'b0;
    model_err  = 1'b0;
    bus_q.delete();
    n_valid = 0; n_req = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (IM_Valid || DM_Valid) n_valid++;
      if (mem_req) n_req++;
    end
    checks++;
    if (n_valid != 0 || n_req != 0) begin
      errors++;
      $display("FAIL post_reset_quiet: got valids=%0d req_cycles=%0d want 0 0", n_valid, n_req);
    end
    // The abandoned write never reached memory and round-robin restarted.
    run_case("post_reset_tie", 1'b1, 15'h0020, 1'b1, 15'h4200, 4'h0, '0, 1, 0);
  endtask

  initial begin
    test_reset();
    test_im_read();
    test_dm_write();
    test_tie_from_reset();
    test_back_to_back();
    test_timeout();
    test_withdraw();
    test_random();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
